// File: rtl/immediate_gen_pipe.sv
// Immediate extender (SEXT / ZEXT / SEXT_SHL / UPPER) behind a valid/ready output stage with one skid entry.
// Define IMM_GEN_PERF_EN to add the 16-bit saturating stall_cnt output.
module immediate_gen_pipe #(
  parameter int unsigned IN_W  = 22,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out
`ifdef IMM_GEN_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [1:0] MODE_SEXT     = 2'b00;
  localparam logic [1:0] MODE_ZEXT     = 2'b01;
  localparam logic [1:0] MODE_SEXT_SHL = 2'b10;
  localparam logic [1:0] MODE_UPPER    = 2'b11;

  // Occupancy: EMPTY (nothing held), MAIN (output register only), FULL (output + skid).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_MAIN  = 2'b01,
    OCC_FULL  = 2'b10
  } occ_t;

  occ_t             state, state_n;
  logic [OUT_W-1:0] skid_q;
  logic [OUT_W-1:0] main_n, skid_n;
  logic [OUT_W-1:0] sext_c, result_c;
  logic             accept_c, pop_c;

  // Extension datapath, evaluated before the result is registered.
  always_comb begin
    sext_c   = OUT_W'($signed(imm_in));
    result_c = sext_c;
    case (mode)
      MODE_SEXT:     result_c = sext_c;
      MODE_ZEXT:     result_c = OUT_W'(imm_in);
      MODE_SEXT_SHL: result_c = sext_c << SHL;
      MODE_UPPER:    result_c = OUT_W'(imm_in) << (OUT_W - IN_W);
      default:       result_c = sext_c;
    endcase
  end

  assign accept_c = in_valid && in_ready;
  assign pop_c    = out_valid && out_ready;

  // Next occupancy and data; skid drains into main ahead of any new entry.
  always_comb begin
    state_n = state;
    main_n  = imm_out;
    skid_n  = skid_q;
    if (flush) begin
      state_n = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept_c) begin
            main_n  = result_c;
            state_n = OCC_MAIN;
          end
        end
        OCC_MAIN: begin
          if (pop_c) begin
            if (accept_c) begin
              main_n = result_c;
            end else begin
              state_n = OCC_EMPTY;
            end
          end else if (accept_c) begin
            skid_n  = result_c;
            state_n = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (pop_c) begin
            main_n  = skid_q;
            state_n = OCC_MAIN;
          end
        end
        default: state_n = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OCC_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      imm_out   <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n != OCC_EMPTY);
      in_ready  <= (state_n != OCC_FULL);
      imm_out   <= main_n;
      skid_q    <= skid_n;
    end
  end

`ifdef IMM_GEN_PERF_EN
  // Saturating count of cycles where a result waits on the consumer; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_immediate_gen_pipe.sv
// Scoreboard bench for immediate_gen_pipe: directed vectors, expected values pushed on acceptance, popped by a monitor.
module tb_immediate_gen_pipe;
  localparam int unsigned IN_W  = 22;
  localparam int unsigned OUT_W = 32;

  localparam logic [1:0] SEXT     = 2'b00;
  localparam logic [1:0] ZEXT     = 2'b01;
  localparam logic [1:0] SEXT_SHL = 2'b10;
  localparam logic [1:0] UPPER    = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;
`ifdef IMM_GEN_PERF_EN
  logic [15:0]      stall_cnt;
`endif

  logic [OUT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  immediate_gen_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHL(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out)
`ifdef IMM_GEN_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one input, wait (bounded) for in_ready, record expected result on acceptance.
  task automatic put(input logic [IN_W-1:0] imm, input logic [1:0] md,
                     input logic [OUT_W-1:0] expv, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    imm_in   = imm;
    mode     = md;
    while (!in_ready && waited < 50) begin
      cycle();
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(expv);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      cycle();
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: an output transfer happens at the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h, required no output (t=%0t)", imm_out, $time);
      end else begin
        check("scoreboard", imm_out, exp_q.pop_front());
      end
    end
  end

  logic [IN_W-1:0]  v_imm [9] = '{22'h1FFFFF, 22'h3FFFFF, 22'h200000, 22'h3FFFFF, 22'h3FFFFF,
                                  22'h100000, 22'h200000, 22'h000001, 22'h3FFFFF};
  logic [1:0]       v_md  [9] = '{SEXT, SEXT, ZEXT, ZEXT, SEXT_SHL, SEXT_SHL, SEXT_SHL, UPPER, UPPER};
  logic [OUT_W-1:0] v_exp [9] = '{32'h001FFFFF, 32'hFFFFFFFF, 32'h00200000, 32'h003FFFFF, 32'hFFFFFFFE,
                                  32'h00200000, 32'hFFC00000, 32'h00000400, 32'hFFFFFC00};

  initial begin
    int w;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    imm_in    = '0;
    mode      = SEXT;
    out_ready = 1'b0;

    repeat (3) cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imm_out", imm_out, 32'd0);
    rst = 1'b0;
    cycle();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // First transaction latency and value.
    out_ready = 1'b1;
    put(22'h200000, SEXT, 32'hFFE00000, w);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_data", imm_out, 32'hFFE00000);

    // Back-to-back stream through every mode: no bubbles.
    for (int i = 0; i < 9; i++) begin
      put(v_imm[i], v_md[i], v_exp[i], w);
      check("no_bubble", 32'(w), 32'd0);
      check("stream_valid", 32'(out_valid), 32'd1);
    end
    drain();

    // Stall: A then B captured, skid full, output held, then ordered release.
    out_ready = 1'b0;
    put(22'h000005, SEXT, 32'h00000005, w);
    check("stall_in_ready_a", 32'(in_ready), 32'd1);
    put(22'h3FFFFF, ZEXT, 32'h003FFFFF, w);
    check("stall_in_ready_b", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", imm_out, 32'h00000005);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("release_b_valid", 32'(out_valid), 32'd1);
    check("release_b_data", imm_out, 32'h003FFFFF);
    check("release_in_ready", 32'(in_ready), 32'd1);
    cycle();
    check("release_empty", 32'(out_valid), 32'd0);
    drain();

    // Flush with both registers full and an input offered.
    out_ready = 1'b0;
    put(22'h000010, SEXT, 32'h00000010, w);
    put(22'h000020, ZEXT, 32'h00000020, w);
    in_valid = 1'b1;
    imm_in   = 22'h000030;
    mode     = SEXT;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_full_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) cycle();
    check("flush_full_quiet", 32'(out_valid), 32'd0);

    // Flush beats a simultaneous accepted input (main full, in_ready=1).
    out_ready = 1'b0;
    put(22'h000040, ZEXT, 32'h00000040, w);
    check("flush_main_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    imm_in   = 22'h000050;
    flush    = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_drop_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (2) cycle();
    check("flush_drop_quiet", 32'(out_valid), 32'd0);

    // Reset mid-stream, then recovery.
    out_ready = 1'b0;
    put(22'h000060, SEXT, 32'h00000060, w);
    put(22'h000070, SEXT, 32'h00000070, w);
    rst = 1'b1;
    cycle();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_data", imm_out, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    cycle();
    check("midrst_ready_after", 32'(in_ready), 32'd1);
    check("midrst_valid_after", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    put(22'h2AAAAA, UPPER, 32'hAAAAA800, w);
    check("recover_data", imm_out, 32'hAAAAA800);
    drain();

`ifdef IMM_GEN_PERF_EN
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("perf_rst", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    put(22'h000001, ZEXT, 32'h00000001, w);
    check("perf_start", 32'(stall_cnt), 32'd0);
    repeat (5) cycle();
    check("perf_five", 32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    cycle();
    check("perf_hold", 32'(stall_cnt), 32'd5);
    drain();
    out_ready = 1'b0;
    put(22'h000002, ZEXT, 32'h00000002, w);
    repeat (65540) cycle();
    check("perf_sat", 32'(stall_cnt), 32'h0000FFFF);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    exp_q.delete();
    check("perf_flush_keep", 32'(stall_cnt), 32'h0000FFFF);
    out_ready = 1'b1;
    cycle();
`endif

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/immediate_gen_pipe.md
IMMEDIATE_GEN_PIPE -- requirements
Module: immediate_gen_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 22: immediate field width in bits.
REQ-002 SHALL have parameter OUT_W, default 32: extended result width; legal only when OUT_W >= IN_W + SHL.
REQ-003 SHALL have parameter SHL, default 1: left-shift amount for mode SEXT_SHL; legal range 0..4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port flush, input, 1: discards all held entries.
REQ-007 SHALL have port in_valid, input, 1: imm_in and mode are valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept an input this cycle.
REQ-009 SHALL have port imm_in, input, IN_W: raw immediate field.
REQ-010 SHALL have port mode, input, 2: extension mode (00 SEXT, 01 ZEXT, 10 SEXT_SHL, 11 UPPER).
REQ-011 SHALL have port out_valid, output, 1: imm_out holds a result.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port imm_out, output, OUT_W: extended immediate.

Function
REQ-014 SEXT SHALL produce imm_in replicated-sign-extended to OUT_W bits.
REQ-015 ZEXT SHALL produce imm_in zero-extended to OUT_W bits.
REQ-016 SEXT_SHL SHALL produce the SEXT value shifted left by SHL, with zero fill in the low SHL bits and truncation to OUT_W.
REQ-017 UPPER SHALL place imm_in in bits [OUT_W-1:OUT_W-IN_W] with zeros below.
REQ-018 An input transfer SHALL occur on a cycle with in_valid && in_ready; an output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-019 Storage SHALL be a main output register plus one skid register; the result SHALL be computed before registering.
REQ-020 Latency SHALL be 1 cycle: a result accepted at edge N SHALL appear on imm_out with out_valid=1 after edge N when the main register is empty or is draining on the same edge.
REQ-021 in_ready SHALL be registered and SHALL equal NOT skid_valid.
REQ-022 When the main register is full, out_ready=0, and an input transfers, the result SHALL go to the skid register; in_ready SHALL be 0 on the following cycle.
REQ-023 When out_ready=1 and the skid register is full, the skid entry SHALL move to the main register in the same cycle, preserving order.
REQ-024 imm_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 With out_ready held at 1 and in_valid held at 1, throughput SHALL be one result per cycle with no bubbles.
REQ-026 flush SHALL clear both valid bits on the next edge and SHALL take priority over a simultaneous input transfer, which is dropped.
REQ-027 The block SHALL never lose, duplicate, or reorder accepted entries, except on flush.

Reset
REQ-028 While rst=1 at an edge: out_valid=0, skid_valid=0, imm_out=0, and in_ready=0.
REQ-029 in_ready SHALL be 1 on the first cycle after rst is deasserted.
REQ-030 rst asserted mid-transfer SHALL discard all held entries; rst SHALL take priority over flush and over any handshake.

Configuration
REQ-031 With macro IMM_GEN_PERF_EN defined, the block SHALL add output stall_cnt (16 bits); it counts cycles with out_valid && !out_ready, saturates at 0xFFFF, is cleared by rst, and is not cleared by flush.
REQ-032 Without IMM_GEN_PERF_EN, stall_cnt and its counter logic SHALL not exist.

Verification
REQ-033 Defaults, mode=SEXT, imm_in=0x200000, out_ready=1 -> imm_out=0xFFE00000, out_valid=1 one cycle after acceptance.
REQ-034 Modes ZEXT/0x200000, SEXT_SHL/0x3FFFFF, UPPER/0x000001 -> 0x00200000, 0xFFFFFFFE, 0x00000400.
REQ-035 out_ready=0 while 2 inputs (A, B) are accepted -> in_ready=0 after B; release out_ready -> A then B on consecutive cycles; imm_out stable during the stall.
REQ-036 flush asserted with in_valid=1 and both registers full -> out_valid=0 next cycle, in_ready=1, input dropped.
REQ-037 rst pulsed mid-stream -> outputs at reset values; in_ready=1 on the cycle after rst falls.
REQ-038 With IMM_GEN_PERF_EN defined, a 5-cycle stall -> stall_cnt=5; forced saturation -> holds at 0xFFFF.
